temporal_decoder_group: RTL and testbench

- Receive-side counterpart to the shared-counter rising-edge delay memory group.
- Watches WIDTH temporally coded spike lines and measures each line's first rising-edge arrival time within a gamma cycle, relative to a local gamma counter.
- At the end of each gamma cycle, presents the WIDTH binary arrival times plus fired flags on a valid/ready output buffer, for binary-domain consumers such as readout logic or a host interface.

---
 rtl/temporal_decoder_group.sv | 98 +++++++++
 tb/tb_temporal_decoder_group.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/temporal_decoder_group.sv
// Records the first rising-edge arrival time of each spike line within a gamma cycle.
// A single-entry valid/ready buffer presents a snapshot of these times at every gamma boundary.
module temporal_decoder_group #(
  parameter int unsigned GAMMA_CYCLE_WIDTH = 16,
  parameter int unsigned WIDTH = 16,
  localparam int unsigned TW = $clog2(GAMMA_CYCLE_WIDTH)
) (
  input  logic                  aclk,
  input  logic                  grst,
  input  logic [WIDTH-1:0]      in,
  output logic [WIDTH*TW-1:0]   out_time,
  output logic [WIDTH-1:0]      out_fired,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  overrun,
  output logic                  gamma_last
);

  localparam logic [TW-1:0] LastCount = TW'(GAMMA_CYCLE_WIDTH - 1);

  logic [TW-1:0]         counter_q, counter_d;
  logic [WIDTH-1:0]      prev_in_q;
  logic [WIDTH-1:0]      rise;
  logic [WIDTH-1:0]      cap_fired_q, cap_fired_d, cap_fired_upd;
  logic [WIDTH*TW-1:0]   cap_time_q, cap_time_d, cap_time_upd;
  logic [WIDTH*TW-1:0]   snap_time;
  logic [WIDTH*TW-1:0]   out_time_q, out_time_d;
  logic [WIDTH-1:0]      out_fired_q, out_fired_d;
  logic                  out_valid_q, out_valid_d;
  logic                  overrun_q, overrun_d;

  assign gamma_last = (counter_q == LastCount);
  // Power-of-two cycle length, so the counter wraps on its own.
  assign counter_d  = counter_q + 1'b1;
  assign rise       = in & ~prev_in_q;

  always_comb begin
    cap_fired_upd = cap_fired_q;
    cap_time_upd  = cap_time_q;
    snap_time     = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (rise[i] && !cap_fired_q[i]) begin
        cap_fired_upd[i]          = 1'b1;
        cap_time_upd[i*TW +: TW]  = counter_q;
      end
      // Lines with no edge report an all-ones time.
      snap_time[i*TW +: TW] = cap_fired_upd[i] ? cap_time_upd[i*TW +: TW] : '1;
    end
    cap_fired_d = gamma_last ? '0 : cap_fired_upd;
    cap_time_d  = gamma_last ? '0 : cap_time_upd;
  end

  always_comb begin
    out_time_d  = out_time_q;
    out_fired_d = out_fired_q;
    out_valid_d = out_valid_q;
    overrun_d   = overrun_q;
    if (gamma_last) begin
      if (!out_valid_q || out_ready) begin
        out_time_d  = snap_time;
        out_fired_d = cap_fired_upd;
        out_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge aclk) begin
    if (grst) begin
      counter_q   <= '0;
      prev_in_q   <= '0;
      cap_fired_q <= '0;
      cap_time_q  <= '0;
      out_time_q  <= '0;
      out_fired_q <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      counter_q   <= counter_d;
      prev_in_q   <= in;
      cap_fired_q <= cap_fired_d;
      cap_time_q  <= cap_time_d;
      out_time_q  <= out_time_d;
      out_fired_q <= out_fired_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign out_time  = out_time_q;
  assign out_fired = out_fired_q;
  assign out_valid = out_valid_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_temporal_decoder_group.sv
// Bench for temporal_decoder_group: directed scenarios plus random traffic,
// each cycle compared with a first-arrival reference model.
module tb_temporal_decoder_group;

  localparam int G  = 16;
  localparam int W  = 16;
  localparam int TW = 4;

  logic              aclk = 1'b0;
  logic              grst = 1'b1;
  logic [W-1:0]      in_v = '0;
  logic [W*TW-1:0]   out_time;
  logic [W-1:0]      out_fired;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic              overrun;
  logic              gamma_last;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state: gamma position and first arrival per line (-1 = none).
  int cnt;
  bit prev[W];
  int first[W];
  int btime[W];
  bit bfired[W];
  bit bvalid;
  bit bover;

  temporal_decoder_group #(.GAMMA_CYCLE_WIDTH(G), .WIDTH(W)) dut (
    .aclk       (aclk),
    .grst       (grst),
    .in         (in_v),
    .out_time   (out_time),
    .out_fired  (out_fired),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .overrun    (overrun),
    .gamma_last (gamma_last)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_step(input bit rst, input logic [W-1:0] v, input bit rdy);
    if (rst) begin
      cnt = 0; bvalid = 0; bover = 0;
      for (int i = 0; i < W; i++) begin
        prev[i] = 0; first[i] = -1; btime[i] = 0; bfired[i] = 0;
      end
      return;
    end
    for (int i = 0; i < W; i++)
      if (v[i] && !prev[i] && first[i] < 0) first[i] = cnt;
    if (cnt == G - 1) begin
      if (!bvalid || rdy) begin
        for (int i = 0; i < W; i++) begin
          bfired[i] = (first[i] >= 0);
          btime[i]  = (first[i] >= 0) ? first[i] : G - 1;
        end
        bvalid = 1;
      end else begin
        bover = 1;
      end
      for (int i = 0; i < W; i++) first[i] = -1;
    end else if (bvalid && rdy) begin
      bvalid = 0;
    end
    for (int i = 0; i < W; i++) prev[i] = v[i];
    cnt = (cnt + 1) % G;
  endtask

  task automatic check_outputs();
    logic [W*TW-1:0] et;
    logic [W-1:0]    ef;
    for (int i = 0; i < W; i++) begin
      et[i*TW +: TW] = btime[i][TW-1:0];
      ef[i]          = bfired[i];
    end
    chk("out_valid", 64'(out_valid), 64'(bvalid));
    chk("out_fired", 64'(out_fired), 64'(ef));
    chk("out_time", 64'(out_time), 64'(et));
    chk("overrun", 64'(overrun), 64'(bover));
    chk("gamma_last", 64'(gamma_last), 64'(cnt == G - 1));
  endtask

  // Entered and left at a falling edge.
  task automatic tick(input bit rst, input logic [W-1:0] v, input bit rdy);
    grst = rst; in_v = v; out_ready = rdy;
    model_step(rst, v, rdy);
    @(posedge aclk);
    @(negedge aclk);
    check_outputs();
  endtask

  function automatic logic [TW-1:0] t_of(input int i);
    return out_time[i*TW +: TW];
  endfunction

  initial begin
    logic [W-1:0] v;
    @(negedge aclk);

    // Single line, ready held high.
    tick(1, '0, 1);
    chk("reset_valid", 64'(out_valid), 64'd0);
    chk("reset_time", 64'(out_time), 64'd0);
    for (int c = 0; c < G; c++) tick(0, (c >= 5 && c < 13) ? W'(1 << 3) : '0, 1);
    chk("s1_valid", 64'(out_valid), 64'd1);
    chk("s1_fired", 64'(out_fired), 64'h0008);
    chk("s1_time3", 64'(t_of(3)), 64'd5);
    chk("s1_time0", 64'(t_of(0)), 64'd15);
    tick(0, '0, 1);
    chk("s1_drop", 64'(out_valid), 64'd0);

    // First edge wins; edge at time 0.
    tick(1, '0, 1);
    for (int c = 0; c < G; c++) begin
      v = '0;
      if (c == 2 || c == 10) v[0] = 1'b1;
      if (c == 0) v[1] = 1'b1;
      tick(0, v, 1);
    end
    chk("s2_time0", 64'(t_of(0)), 64'd2);
    chk("s2_time1", 64'(t_of(1)), 64'd0);
    chk("s2_fired", 64'(out_fired), 64'h0003);

    // Edge on the boundary cycle, held across it.
    tick(1, '0, 1);
    for (int c = 0; c < G; c++) tick(0, (c == G - 1) ? W'(1 << 7) : '0, 1);
    chk("s3_time7", 64'(t_of(7)), 64'd15);
    chk("s3_fired7", 64'(out_fired[7]), 64'd1);
    for (int c = 0; c < G; c++) tick(0, W'(1 << 7), 1);
    chk("s3_refire7", 64'(out_fired[7]), 64'd0);

    // Overrun, then accept exactly on the boundary.
    tick(1, '0, 0);
    for (int c = 0; c < G; c++) tick(0, (c == 4) ? W'(1 << 2) : '0, 0);
    for (int c = 0; c < G; c++) tick(0, (c == 9) ? W'(1 << 2) : '0, 0);
    chk("s4_keep", 64'(t_of(2)), 64'd4);
    chk("s4_over", 64'(overrun), 64'd1);
    for (int c = 0; c < G; c++) tick(0, (c == 6) ? W'(1 << 2) : '0, c == G - 1);
    chk("s4_valid", 64'(out_valid), 64'd1);
    chk("s4_new", 64'(t_of(2)), 64'd6);

    // Reset mid-cycle discards partial capture and pending snapshot.
    tick(1, '0, 0);
    for (int c = 0; c < G; c++) tick(0, '0, 0);
    for (int c = 0; c < 8; c++) tick(0, (c == 3) ? W'(1 << 5) : '0, 0);
    chk("s5_pre", 64'(out_valid), 64'd1);
    tick(1, '0, 0);
    chk("s5_valid", 64'(out_valid), 64'd0);
    chk("s5_over", 64'(overrun), 64'd0);
    for (int c = 0; c < G; c++) tick(0, '0, 1);
    chk("s5_fired5", 64'(out_fired[5]), 64'd0);

    // Line already high when reset releases.
    tick(1, W'(1 << 4), 1);
    tick(1, W'(1 << 4), 1);
    for (int c = 0; c < G; c++) tick(0, W'(1 << 4), 1);
    chk("s6_time4", 64'(t_of(4)), 64'd0);
    chk("s6_fired4", 64'(out_fired[4]), 64'd1);

    // Random traffic with sparse spikes, random ready, rare resets.
    for (int n = 0; n < 800; n++) begin
      v = W'($urandom & $urandom & $urandom);
      tick($urandom_range(0, 149) == 0, v, $urandom_range(0, 3) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
